// File: rtl/chorus_multi.sv
// Multi-voice chorus stage: sums VOICES swept-delay taps from the shared delay
// line with optional dry signal, then shifts and saturates to one output sample.
module chorus_multi #(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 13,
   parameter int SAMPLERATE   = 48000,
   parameter int VOICES       = 3,
   parameter int MIN_DELAY_MS = 10,
   parameter int UPDATE_N     = 10,
   parameter int SHIFT        = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  my_turn,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [1:0]            mix_mode,
   input  logic [DATA_WIDTH-1:0] sram_data_in,
   input  logic                  sram_read_finish,
   output logic                  sram_rd,
   output logic [ADDR_WIDTH-1:0] sram_offset,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int ACC_W = DATA_WIDTH + 4;
   localparam int CNT_W = (UPDATE_N > 0) ? $clog2(UPDATE_N + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DONE
   } state_t;

   state_t                  state, state_next;
   logic signed [ACC_W-1:0] acc, acc_next;
   logic signed [ACC_W-1:0] sum, shifted;
   logic [2:0]              voice, voice_next;
   logic [1:0]              mode, mode_next;
   logic                    rd_next;
   logic [ADDR_WIDTH-1:0]   offset_next;
   logic                    done_next;
   logic [DATA_WIDTH-1:0]   data_out_next;
   logic                    sweep;

   logic [ADDR_WIDTH-1:0]   tap_table [16];
   logic [3:0]              voice_idx [VOICES];
   logic                    voice_dir [VOICES];
   logic [3:0]              next_idx;
   logic [CNT_W-1:0]        counter;

   for (genvar k = 0; k < 16; k++) begin : g_tap
      localparam longint unsigned TAP_VAL = 4 * (MIN_DELAY_MS + k) * SAMPLERATE / 1000;
      assign tap_table[k] = TAP_VAL[ADDR_WIDTH-1:0];
   end

   always_comb begin
      next_idx = voice_idx[0];
      for (int unsigned v = 0; v < VOICES; v++) begin
         if (voice + 3'd1 == 3'(v)) next_idx = voice_idx[v];
      end
   end

   always_comb begin
      state_next    = state;
      acc_next      = acc;
      voice_next    = voice;
      mode_next     = mode;
      rd_next       = 1'b0;
      offset_next   = sram_offset;
      done_next     = 1'b0;
      data_out_next = data_out;
      sweep         = 1'b0;
      sum           = acc + {{4{sram_data_in[DATA_WIDTH-1]}}, sram_data_in};
      shifted       = sum >>> SHIFT;

      case (state)
         ST_IDLE: begin
            if (cs && my_turn) begin
               mode_next = mix_mode;
               if (mix_mode == 2'd0) begin
                  data_out_next = data_in;
                  done_next     = 1'b1;
                  state_next    = ST_DONE;
               end else begin
                  acc_next    = (mix_mode == 2'd2) ? '0
                                : {{4{data_in[DATA_WIDTH-1]}}, data_in};
                  voice_next  = '0;
                  rd_next     = 1'b1;
                  offset_next = tap_table[voice_idx[0]];
                  state_next  = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (sram_read_finish) begin
               acc_next = sum;
               if (voice != 3'(VOICES - 1)) begin
                  voice_next  = voice + 3'd1;
                  rd_next     = 1'b1;
                  offset_next = tap_table[next_idx];
               end else begin
                  // upper bits all equal the sign bit means the value fits
                  if (shifted[ACC_W-1:DATA_WIDTH-1] == '0 ||
                      shifted[ACC_W-1:DATA_WIDTH-1] == '1)
                     data_out_next = shifted[DATA_WIDTH-1:0];
                  else if (shifted[ACC_W-1])
                     data_out_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                  else
                     data_out_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
                  done_next  = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            sweep      = (mode != 2'd0);
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         voice       <= '0;
         mode        <= '0;
         sram_rd     <= 1'b0;
         sram_offset <= '0;
         done        <= 1'b0;
         data_out    <= '0;
      end else begin
         state       <= state_next;
         acc         <= acc_next;
         voice       <= voice_next;
         mode        <= mode_next;
         sram_rd     <= rd_next;
         sram_offset <= offset_next;
         done        <= done_next;
         data_out    <= data_out_next;
      end
   end

   // triangle sweep: each voice bounces between table ends, reflecting at 0 and 15
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter <= CNT_W'(UPDATE_N);
         for (int unsigned v = 0; v < VOICES; v++) begin
            voice_idx[v] <= 4'((3 + 5 * v) % 16);
            voice_dir[v] <= (v % 2 == 0);
         end
      end else if (sweep) begin
         if (counter == '0) begin
            counter <= CNT_W'(UPDATE_N);
            for (int unsigned v = 0; v < VOICES; v++) begin
               if (voice_dir[v]) begin
                  if (voice_idx[v] == 4'd15) begin
                     voice_idx[v] <= 4'd14;
                     voice_dir[v] <= 1'b0;
                  end else begin
                     voice_idx[v] <= voice_idx[v] + 4'd1;
                  end
               end else begin
                  if (voice_idx[v] == 4'd0) begin
                     voice_idx[v] <= 4'd1;
                     voice_dir[v] <= 1'b1;
                  end else begin
                     voice_idx[v] <= voice_idx[v] - 4'd1;
                  end
               end
            end
         end else begin
            counter <= counter - 1'b1;
         end
      end
   end

endmodule
